// File: rtl/float_pkg.sv
// Shared binary32 field widths, constants and FSM encoding for the float divider.
package float_pkg;
    localparam int SIGN     = 1;
    localparam int EXP      = 8;
    localparam int MANT     = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]    QNAN    = 32'h7FC0_0000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [SIGN-1:0] sign;
        logic [EXP-1:0]  exp;
        logic [MANT-1:0] mant;
    } fp32_t;
endpackage

// File: rtl/fdiv_mant_core.sv
// Radix-2 restoring mantissa divider: Q = floor(Am * 2^24 / Bm), one quotient bit per cycle.
// start loads the operands; done pulses one cycle after the 25th step.
module fdiv_mant_core
    import float_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [MANT:0]   Am,
    input  logic [MANT:0]   Bm,
    output logic            done,
    output logic [MANT+1:0] Q
);
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [MANT+1:0] rem_q, rem_d;
    logic [MANT+1:0] quo_q, quo_d;
    logic [MANT:0]   bm_q, bm_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [MANT:0]   diff;
    logic            ge;

    always_comb begin
        ge     = rem_q >= {1'b0, bm_q};
        // When ge holds the difference is below Bm, so the low bits are exact.
        diff   = rem_q[MANT:0] - bm_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rem_d  = rem_q;
        quo_d  = quo_q;
        bm_d   = bm_q;
        cnt_d  = cnt_q;
        if (start) begin
            busy_d = 1'b1;
            rem_d  = {1'b0, Am};
            quo_d  = '0;
            bm_d   = Bm;
            cnt_d  = 5'(MANT + 1);
        end else if (busy_q) begin
            quo_d = {quo_q[MANT:0], ge};
            rem_d = ge ? {diff, 1'b0} : {rem_q[MANT:0], 1'b0};
            if (cnt_q == 5'd0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            bm_q   <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            bm_q   <= bm_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done = done_q;
    assign Q    = quo_q;
endmodule

// File: rtl/float_div.sv
// Sequential binary32 divider (truncating, denormals flushed) behind valid/ready handshakes.
// Operands are registered on accept; specials resolve one edge later, normal results 26 edges later.
module float_div
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] O,
    output logic        overflow,
    output logic        nan,
    output logic        div_by_zero
);
    logic [1:0]      state_q, state_d;
    fp32_t           a_q, a_d, b_q, b_d;
    logic [31:0]     o_q, o_d;
    logic            ovf_q, ovf_d, nan_q, nan_d, dbz_q, dbz_d;
    logic            core_start, core_done;
    logic [MANT+1:0] q;

    logic            a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, is_special;
    logic [SIGN-1:0] s;
    logic [31:0]     inf_o, zero_o;
    logic [MANT-1:0] mant_n;
    logic signed [9:0] e;

    assign core_start = (state_q == IDLE) && in_valid;

    fdiv_mant_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .Am    ({1'b1, A[MANT-1:0]}),
        .Bm    ({1'b1, B[MANT-1:0]}),
        .done  (core_done),
        .Q     (q)
    );

    always_comb begin
        a_zero = a_q.exp == '0;
        b_zero = b_q.exp == '0;
        a_inf  = (a_q.exp == EXP_MAX) && (a_q.mant == '0);
        b_inf  = (b_q.exp == EXP_MAX) && (b_q.mant == '0);
        a_nan  = (a_q.exp == EXP_MAX) && (a_q.mant != '0);
        b_nan  = (b_q.exp == EXP_MAX) && (b_q.mant != '0);
        is_special = a_zero || b_zero || (a_q.exp == EXP_MAX) || (b_q.exp == EXP_MAX);
        s      = a_q.sign ^ b_q.sign;
        inf_o  = {s, EXP_MAX, {MANT{1'b0}}};
        zero_o = {s, 31'd0};
        // Q lies in [2^23, 2^25); its top bit picks the normalization shift.
        mant_n = q[MANT+1] ? q[MANT:1] : q[MANT-1:0];
        e      = {2'b00, a_q.exp} - {2'b00, b_q.exp} + 10'(EXP_BIAS) - 10'(!q[MANT+1]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        ovf_d   = ovf_q;
        nan_d   = nan_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (is_special) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    nan_d   = 1'b0;
                    dbz_d   = 1'b0;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        o_d   = QNAN;
                        nan_d = 1'b1;
                    end else if (b_zero && !a_inf) begin
                        o_d   = inf_o;
                        dbz_d = 1'b1;
                    end else if (a_inf) begin
                        o_d = inf_o;
                    end else begin
                        o_d = zero_o;
                    end
                end else if (core_done) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    nan_d   = 1'b0;
                    dbz_d   = 1'b0;
                    if (e >= 10'sd255) begin
                        o_d   = inf_o;
                        ovf_d = 1'b1;
                    end else if (e <= 10'sd0) begin
                        o_d = zero_o;
                    end else begin
                        o_d = {s, e[EXP-1:0], mant_n};
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
            nan_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            ovf_q   <= ovf_d;
            nan_q   <= nan_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign O           = o_q;
    assign overflow    = ovf_q;
    assign nan         = nan_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: directed spec cases, backpressure, mid-run reset, random ops vs model.
module tb_float_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] O;
    logic        overflow, nan, div_by_zero;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        ovf;
        logic        nan;
        logic        dbz;
    } res_t;

    float_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .O           (O),
        .overflow    (overflow),
        .nan         (nan),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference: classify operands, then divide the 24-bit mantissas with integer arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        logic   sg, az, ai, an, bz, bi, bn;
        int     ea, eb, e;
        longint am, bm, qq, mant;
        r  = '0;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = ea == 0;
        bz = eb == 0;
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.o = 32'h7FC00000; r.nan = 1'b1;
        end else if (bz && !ai) begin
            r.o = {sg, 8'hFF, 23'd0}; r.dbz = 1'b1;
        end else if (ai) begin
            r.o = {sg, 8'hFF, 23'd0};
        end else if (az || bi) begin
            r.o = {sg, 31'd0};
        end else begin
            am = 64'h80_0000 + longint'(a[22:0]);
            bm = 64'h80_0000 + longint'(b[22:0]);
            qq = (am * 64'h100_0000) / bm;
            if (qq >= 64'h100_0000) begin
                mant = (qq / 2) % 64'h80_0000;
                e    = ea - eb + 127;
            end else begin
                mant = qq % 64'h80_0000;
                e    = ea - eb + 126;
            end
            if (e >= 255) begin
                r.o = {sg, 8'hFF, 23'd0}; r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.o = {sg, 31'd0};
            end else begin
                r.o = {sg, 8'(e), 23'(mant)};
            end
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
            return 1;
        return 26;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = int'($urandom_range(0, 15));
        case (sel)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: v[30:23] = 8'hFF;
            3: v[30:0] = 31'd0;
            4, 5: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    function automatic res_t observed();
        return {O, overflow, nan, div_by_zero};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = $urandom; B = $urandom;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input res_t want,
                          input int want_lat, input string tag, input int hold);
        int lat;
        issue(a, b);
        wait_result(lat);
        check({tag, " latency"}, 64'(lat), 64'(want_lat));
        check({tag, " result"}, 64'(observed()), 64'(want));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            A = $urandom; B = $urandom; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, " held result"}, 64'(observed()), 64'(want));
            check({tag, " held in_ready"}, 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = hold > 0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (hold > 0) begin
            check({tag, " in_ready after release"}, 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end
    endtask

    logic [31:0] dir_a [7] = '{32'h40C00000, 32'h3F800000, 32'h7F000000, 32'h00800000,
                               32'hBF800000, 32'h00000000, 32'h7F800000};
    logic [31:0] dir_b [7] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h7F000000,
                               32'h00000000, 32'h00000000, 32'h7F800000};
    res_t dir_r [7] = '{{32'h40400000, 1'b0, 1'b0, 1'b0}, {32'h3EAAAAAA, 1'b0, 1'b0, 1'b0},
                        {32'h7F800000, 1'b1, 1'b0, 1'b0}, {32'h00000000, 1'b0, 1'b0, 1'b0},
                        {32'hFF800000, 1'b0, 1'b0, 1'b1}, {32'h7FC00000, 1'b0, 1'b1, 1'b0},
                        {32'h7FC00000, 1'b0, 1'b1, 1'b0}};
    int dir_lat [7] = '{26, 26, 26, 26, 1, 1, 1};

    initial begin
        logic [31:0] ra, rb;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset outputs", 64'(observed()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op(dir_a[i], dir_b[i], dir_r[i], dir_lat[i], $sformatf("directed%0d", i), 0);

        // Backpressure: result held for 10 cycles while A/B and in_valid churn.
        run_op(32'h40C00000, 32'h40000000, dir_r[0], 26, "backpressure", 10);
        run_op(32'h3F800000, 32'h40400000, dir_r[1], 26, "after release", 0);

        // Asynchronous reset in the middle of a calculation.
        issue(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset in_ready", 64'(in_ready), 64'(1));
        check("async reset out_valid", 64'(out_valid), 64'(0));
        check("async reset outputs", 64'(observed()), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, dir_r[0], 26, "post reset 6/2", 0);

        for (int i = 0; i < 150; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            run_op(ra, rb, model(ra, rb), exp_latency(ra, rb),
                   $sformatf("random%0d %h/%h", i, ra, rb), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
